// File: rtl/fx_div_unit.sv
// fx_div_unit: sequential unsigned fixed-point divider coprocessor.
// Computes floor((dividend << FRAC) / divisor) with a restoring
// shift-subtract engine, one quotient bit per clock (QW iterations).
// Divide-by-zero saturates the quotient to all ones and flags it.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        launch request, sampled on the rising edge
//   dividend_i     unsigned dividend (DW bits), sampled with start_i
//   divisor_i      unsigned divisor (VW bits), sampled with start_i
//   busy_o         high while iterating
//   done_o         one-cycle completion pulse
//   quotient_o     result (QW = DW+FRAC bits), held until next completion
//   div_by_zero_o  set with done_o when the divisor was zero
module fx_div_unit #(
    parameter int unsigned DW   = 16,
    parameter int unsigned VW   = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [DW-1:0]        dividend_i,
    input  logic [VW-1:0]        divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DW+FRAC-1:0]   quotient_o,
    output logic                 div_by_zero_o
);

    localparam int unsigned QW = DW + FRAC;
    localparam int unsigned CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   ext_q, ext_d;     // extended dividend, shifted out MSB first
    logic [VW-1:0]   div_q, div_d;
    logic [VW-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
    logic [QW-1:0]   acc_q, acc_d;     // quotient bits gathered so far
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic            dbz_q, dbz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [VW:0]     rem_shift;
    logic [VW:0]     trial;
    logic            qbit;

    // Trial subtraction in VW+1 bits; the sign bit is reliable because the
    // shifted remainder is always below twice the divisor.
    always_comb begin
        rem_shift = {rem_q, ext_q[QW-1]};
        trial     = rem_shift - {1'b0, div_q};
        qbit      = ~trial[VW];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        div_d   = div_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new launch exactly like IDLE (back-to-back).
                state_d = ST_IDLE;
                if (start_i) begin
                    if (divisor_i != '0) begin
                        ext_d   = {dividend_i, {FRAC{1'b0}}};
                        div_d   = divisor_i;
                        rem_d   = '0;
                        acc_d   = '0;
                        cnt_d   = CW'(QW);
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end else begin
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                rem_d = qbit ? trial[VW-1:0] : rem_shift[VW-1:0];
                ext_d = {ext_q[QW-2:0], 1'b0};
                acc_d = {acc_q[QW-2:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = acc_d;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ext_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fx_div_unit.sv
// Directed testbench for fx_div_unit (default parameters, QW = 24).
module tb_fx_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [23:0] quotient;
    logic        dbz;

    int n_total = 0;
    int n_bad   = 0;

    fx_div_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands at the falling edge; returns 1ns after the sampling edge E0.
    task automatic start_op(input logic [15:0] dd, input logic [15:0] dv);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat0 is the number of edges already elapsed since E0.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                             input logic [23:0] exp_q, input logic exp_dbz);
        int          lat;
        int          busy_n;
        logic        overlap;
        logic        stable;
        logic [23:0] q0;
        lat     = lat0;
        busy_n  = 0;
        overlap = 1'b0;
        stable  = 1'b1;
        q0      = quotient;
        while (!done && lat < 200) begin
            if (busy) busy_n++;
            if (quotient !== q0) stable = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done && busy) overlap = 1'b1;
        end
        check({tag, ".done"},    32'(done),     32'd1);
        check({tag, ".lat"},     32'(lat),      32'(exp_lat));
        check({tag, ".q"},       32'(quotient), 32'(exp_q));
        check({tag, ".dbz"},     32'(dbz),      32'(exp_dbz));
        check({tag, ".busy_n"},  32'(busy_n),   32'(exp_lat - lat0));
        check({tag, ".overlap"}, 32'(overlap),  32'd0);
        check({tag, ".stable"},  32'(stable),   32'd1);
    endtask

    // Done must drop after exactly one cycle.
    task automatic check_pulse_end(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".done_w"}, 32'(done), 32'd0);
        check({tag, ".busy_a"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic seen_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy),     32'd0);
        check("rst.done", 32'(done),     32'd0);
        check("rst.q",    32'(quotient), 32'd0);
        check("rst.dbz",  32'(dbz),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: 0x8000/4
        start_op(16'h8000, 16'h0004);
        wait_done("t1", 0, 24, 24'h200000, 1'b0);
        check_pulse_end("t1");

        // Truncation and extremes
        start_op(16'h8000, 16'd400);
        wait_done("t2a", 0, 24, 24'h0051EB, 1'b0);
        check_pulse_end("t2a");
        start_op(16'hFFFF, 16'hFFFF);
        wait_done("t2b", 0, 24, 24'h000100, 1'b0);
        check_pulse_end("t2b");
        start_op(16'hFFFF, 16'h0001);
        wait_done("t2c", 0, 24, 24'hFFFF00, 1'b0);
        check_pulse_end("t2c");

        // Divide by zero: done right after the sampling edge
        start_op(16'h1234, 16'h0000);
        wait_done("t3a", 0, 0, 24'hFFFFFF, 1'b1);
        check_pulse_end("t3a");
        start_op(16'h0001, 16'h0002);
        wait_done("t3b", 0, 24, 24'h000080, 1'b0);
        check_pulse_end("t3b");

        // Start during RUN is ignored
        start_op(16'h8000, 16'h0004);
        repeat (4) @(posedge clk);
        #1;
        start_op(16'h0001, 16'h0001);
        wait_done("t4", 5, 24, 24'h200000, 1'b0);
        check_pulse_end("t4");

        // Async reset mid-operation
        start_op(16'h8000, 16'h0004);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5.busy", 32'(busy),     32'd0);
        check("t5.done", 32'(done),     32'd0);
        check("t5.q",    32'(quotient), 32'd0);
        check("t5.dbz",  32'(dbz),      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("t5.no_done", 32'(seen_done), 32'd0);
        start_op(16'h0003, 16'h0003);
        wait_done("t5b", 0, 24, 24'h000100, 1'b0);
        check_pulse_end("t5b");

        // Back-to-back: new Start sampled in the DONE cycle
        start_op(16'h8000, 16'h0004);
        wait_done("t6a", 0, 24, 24'h200000, 1'b0);
        start_op(16'h0001, 16'h0004);
        check("t6.busy", 32'(busy), 32'd1);
        wait_done("t6b", 0, 24, 24'h000040, 1'b0);
        check_pulse_end("t6b");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
